tl_ram_responder: RTL and testbench

TileLink-UL responder (slave end) backed by a synthesizable byte-enabled word RAM, answering channel-A requests from `tl_memory_controller_master` with channel-D responses. It replaces the `tl_memory_controller_slave` + `dpi_mem` pair in synthesizable tops. It supports a single outstanding transaction and has a parameterizable response latency for exercising master-side stall handling.

---
 rtl/tl_ram_responder_pkg.sv | 36 +++
 rtl/tl_ram_responder_if.sv | 41 ++++
 rtl/tl_ram_storage.sv | 34 +++
 rtl/tl_ram_responder.sv | 128 ++++++++++++
 tb/tb_tl_ram_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_ram_responder_pkg.sv
// Shared types for the TileLink-UL RAM responder.
//   tl_a_opcode_e   : channel-A request opcodes understood by the responder
//   tl_d_opcode_e   : channel-D response opcodes
//   tl_resp_state_e : responder FSM states
//   size_aligned()  : true when a byte address is aligned to 2^size (size 3 never is)
package tl_ram_responder_pkg;

   typedef enum logic [2:0] {
      PUT_FULL    = 3'd0,
      PUT_PARTIAL = 3'd1,
      GET         = 3'd4
   } tl_a_opcode_e;

   typedef enum logic [2:0] {
      ACCESS_ACK      = 3'd0,
      ACCESS_ACK_DATA = 3'd1
   } tl_d_opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } tl_resp_state_e;

   function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] addr_lsb);
      logic ok;
      case (size)
         2'd0:    ok = 1'b1;
         2'd1:    ok = ~addr_lsb[0];
         2'd2:    ok = (addr_lsb == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
// TileLink-UL channel A/D bundle between a single master and the RAM responder.
//   a_* : request channel (master -> responder), a_ready flows back
//   d_* : response channel (responder -> master), d_ready flows back
// Modports: master (requester side), slave (responder side).
interface tl_ram_responder_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int SOURCE_WIDTH = 2
) ();

   logic                    a_valid;
   logic                    a_ready;
   logic [2:0]              a_opcode;
   logic [1:0]              a_size;
   logic [SOURCE_WIDTH-1:0] a_source;
   logic [ADDR_WIDTH-1:0]   a_address;
   logic [3:0]              a_mask;
   logic [31:0]             a_data;

   logic                    d_valid;
   logic                    d_ready;
   logic [2:0]              d_opcode;
   logic [1:0]              d_size;
   logic [SOURCE_WIDTH-1:0] d_source;
   logic                    d_denied;
   logic [31:0]             d_data;

   modport master (
      output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
      input  a_ready,
      input  d_valid, d_opcode, d_size, d_source, d_denied, d_data,
      output d_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
      output a_ready,
      output d_valid, d_opcode, d_size, d_source, d_denied, d_data,
      input  d_ready
   );

endinterface

// File: rtl/tl_ram_storage.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read.
//   clk_i   : clock
//   en_i    : access strobe; a write when any be_i bit is set, otherwise a read
//   be_i    : byte-lane write enables
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data, updated on the edge of a read access and held otherwise
// Contents and the read register are not reset.
module tl_ram_storage #(
   parameter int WORDS      = 4096,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       en_i,
   input  logic [DATA_WIDTH/8-1:0]    be_i,
   input  logic [$clog2(WORDS)-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]      wdata_i,
   output logic [DATA_WIDTH-1:0]      rdata_o
);

   localparam int BW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < BW; b++) begin
            if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
         if (be_i == '0) rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL responder backed by a byte-enabled word RAM, one transaction in flight.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   tl      : channel A/D bundle (slave modport)
// Memory is touched on the acceptance edge; the response is presented LATENCY
// cycles later and held until d_ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | a_ready high, waiting for a request
// ST_WAIT | request done in RAM, counting down the response latency
// ST_RESP | d_valid high, D fields held until d_ready
module tl_ram_responder
   import tl_ram_responder_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_WORDS    = 4096,
   parameter int LATENCY      = 1,
   parameter int SOURCE_WIDTH = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   tl_ram_responder_if.slave tl
);

   localparam int         IDX_W = $clog2(MEM_WORDS);
   localparam logic [3:0] LAT   = 4'(LATENCY);

   tl_resp_state_e          state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [SOURCE_WIDTH-1:0] source_q, source_d;
   logic [1:0]              size_q, size_d;
   tl_d_opcode_e            opcode_q, opcode_d;
   logic                    denied_q, denied_d;
   logic                    data_en_q, data_en_d;

   logic                    accept;
   logic                    is_get;
   logic                    is_put;
   logic                    legal;
   logic [ADDR_WIDTH-1:0]   word_idx;
   logic [DATA_WIDTH-1:0]   rdata;

   assign tl.a_ready = (state_q == ST_IDLE) && !reset_i;
   assign accept     = tl.a_valid && tl.a_ready;

   assign is_get   = (tl.a_opcode == GET);
   assign is_put   = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);
   assign word_idx = tl.a_address >> 2;
   assign legal    = (is_get || is_put)
                     && size_aligned(tl.a_size, tl.a_address[1:0])
                     && (word_idx < ADDR_WIDTH'(MEM_WORDS));

   // Denied requests never reach the RAM; a Put supplies byte enables, a Get reads.
   tl_ram_storage #(
      .WORDS      (MEM_WORDS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_storage (
      .clk_i   (clk_i),
      .en_i    (accept && legal),
      .be_i    (is_put ? tl.a_mask : 4'h0),
      .addr_i  (word_idx[IDX_W-1:0]),
      .wdata_i (tl.a_data),
      .rdata_o (rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      source_d  = source_q;
      size_d    = size_q;
      opcode_d  = opcode_q;
      denied_d  = denied_q;
      data_en_d = data_en_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               source_d  = tl.a_source;
               size_d    = tl.a_size;
               opcode_d  = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
               denied_d  = !legal;
               data_en_d = legal && is_get;
               cnt_d     = LAT;
               state_d   = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: begin
            if (tl.d_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         source_q  <= '0;
         size_q    <= '0;
         opcode_q  <= ACCESS_ACK;
         denied_q  <= 1'b0;
         data_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         source_q  <= source_d;
         size_q    <= size_d;
         opcode_q  <= opcode_d;
         denied_q  <= denied_d;
         data_en_q <= data_en_d;
      end
   end

   // The RAM read register holds the word until the next access, and the
   // responder takes no new access until the response is consumed.
   assign tl.d_valid  = (state_q == ST_RESP);
   assign tl.d_opcode = opcode_q;
   assign tl.d_size   = size_q;
   assign tl.d_source = source_q;
   assign tl.d_denied = denied_q;
   assign tl.d_data   = data_en_q ? rdata : '0;

endmodule

// File: tb/tb_tl_ram_responder.sv
module tb_tl_ram_responder;
   import tl_ram_responder_pkg::*;

   localparam int LAT       = 3;
   localparam int MEM_WORDS = 4096;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;

   always #5 clk_i = ~clk_i;

   tl_ram_responder_if #(.ADDR_WIDTH(32), .SOURCE_WIDTH(2)) tl ();

   tl_ram_responder #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .MEM_WORDS    (MEM_WORDS),
      .LATENCY      (LAT),
      .SOURCE_WIDTH (2)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tl      (tl)
   );

   typedef struct {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic [1:0]  source;
      logic        denied;
      logic [31:0] data;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] model_mem [int];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Scoreboard: every D handshake pops one expected response.
   always @(negedge clk_i) begin
      if (!reset_i && tl.d_valid && tl.d_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(exp_q.size()), 32'd1);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("d_opcode", 32'(tl.d_opcode), 32'(e.opcode));
            check("d_size",   32'(tl.d_size),   32'(e.size));
            check("d_source", 32'(tl.d_source), 32'(e.source));
            check("d_denied", 32'(tl.d_denied), 32'(e.denied));
            check("d_data",   tl.d_data,        e.data);
         end
      end
   end

   task automatic send_a(input logic [2:0] op, input logic [1:0] sz, input logic [1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
      int          n;
      int          idx;
      logic        ok;
      logic [31:0] w;
      resp_t       e;
      n = 0;
      while (tl.a_ready !== 1'b1 && n < 20) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("a_ready_wait", 32'(tl.a_ready), 32'd1);
      tl.a_valid   = 1'b1;
      tl.a_opcode  = op;
      tl.a_size    = sz;
      tl.a_source  = src;
      tl.a_address = addr;
      tl.a_mask    = mask;
      tl.a_data    = data;
      idx = int'(addr >> 2);
      ok  = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (sz != 2'd3)
            && ((addr & ((32'd1 << sz) - 32'd1)) == 32'd0)
            && ((addr >> 2) < 32'(MEM_WORDS));
      e.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
      e.size   = sz;
      e.source = src;
      e.denied = !ok;
      e.data   = 32'd0;
      if (ok && op != 3'd4) begin
         w = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
         for (int b = 0; b < 4; b++) if (mask[b]) w[b*8 +: 8] = data[b*8 +: 8];
         model_mem[idx] = w;
      end else if (ok) begin
         e.data = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
      end
      exp_q.push_back(e);
      @(posedge clk_i); #1;
      tl.a_valid = 1'b0;
   endtask

   task automatic wait_resp(input int stall, input bit early, input bit poke);
      int          n;
      logic [31:0] s_data;
      logic [2:0]  s_op;
      logic [1:0]  s_src;
      n = 0;
      if (early) tl.d_ready = 1'b1;
      while (tl.d_valid !== 1'b1 && n < 40) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("d_valid_latency", 32'(n), 32'(LAT));
      s_data = tl.d_data;
      s_op   = tl.d_opcode;
      s_src  = tl.d_source;
      for (int i = 0; i < stall; i++) begin
         if (poke) begin
            tl.a_valid   = 1'b1;
            tl.a_opcode  = 3'd0;
            tl.a_size    = 2'd2;
            tl.a_address = 32'h10;
            tl.a_mask    = 4'hF;
            tl.a_data    = 32'h1234_5678;
         end
         @(posedge clk_i); #1;
         check("stall_a_ready",  32'(tl.a_ready),  32'd0);
         check("stall_d_valid",  32'(tl.d_valid),  32'd1);
         check("stall_d_data",   tl.d_data,        s_data);
         check("stall_d_opcode", 32'(tl.d_opcode), 32'(s_op));
         check("stall_d_source", 32'(tl.d_source), 32'(s_src));
      end
      tl.a_valid = 1'b0;
      tl.d_ready = 1'b1;
      @(posedge clk_i); #1;
      tl.d_ready = 1'b0;
      check("post_hs_a_ready", 32'(tl.a_ready), 32'd1);
      check("post_hs_d_valid", 32'(tl.d_valid), 32'd0);
   endtask

   task automatic txn(input logic [2:0] op, input logic [1:0] sz, input logic [1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input int stall, input bit early, input bit poke);
      send_a(op, sz, src, addr, mask, data);
      wait_resp(stall, early, poke);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      tl.a_valid   = 1'b0;
      tl.a_opcode  = 3'd0;
      tl.a_size    = 2'd0;
      tl.a_source  = 2'd0;
      tl.a_address = 32'd0;
      tl.a_mask    = 4'd0;
      tl.a_data    = 32'd0;
      tl.d_ready   = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_a_ready",  32'(tl.a_ready),  32'd0);
      check("rst_d_valid",  32'(tl.d_valid),  32'd0);
      check("rst_d_denied", 32'(tl.d_denied), 32'd0);
      check("rst_d_opcode", 32'(tl.d_opcode), 32'd0);
      check("rst_d_size",   32'(tl.d_size),   32'd0);
      check("rst_d_source", 32'(tl.d_source), 32'd0);
      check("rst_d_data",   tl.d_data,        32'd0);
      reset_i = 1'b0;
      #1;
      check("a_ready_after_rst", 32'(tl.a_ready), 32'd1);

      // Full put then get, then partial put then get.
      txn(3'd0, 2'd2, 2'd1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, 0);
      txn(3'd4, 2'd2, 2'd1, 32'h10, 4'hF, 32'h0,         0, 0, 0);
      txn(3'd1, 2'd2, 2'd2, 32'h10, 4'h2, 32'h0000_AA00, 0, 0, 0);
      txn(3'd4, 2'd2, 2'd3, 32'h10, 4'hF, 32'h0,         0, 0, 0);

      // Held-off response with a request waved at the busy responder.
      txn(3'd4, 2'd2, 2'd0, 32'h10, 4'hF, 32'h0, 5, 0, 1);

      // Denied requests leave memory alone.
      txn(3'd4, 2'd2, 2'd1, 32'h12,               4'hF, 32'h0,         0, 0, 0);
      txn(3'd4, 2'd2, 2'd2, 32'(MEM_WORDS * 4),   4'hF, 32'h0,         0, 0, 0);
      txn(3'd2, 2'd2, 2'd3, 32'h10,               4'hF, 32'hCAFE_F00D, 0, 0, 0);
      txn(3'd0, 2'd2, 2'd0, 32'h11,               4'hF, 32'h5555_5555, 0, 0, 0);
      txn(3'd4, 2'd3, 2'd1, 32'h10,               4'hF, 32'h0,         0, 0, 0);
      txn(3'd4, 2'd2, 2'd1, 32'h10,               4'hF, 32'h0,         0, 0, 0);

      // Sub-word gets and a d_ready that is high long before the response.
      txn(3'd4, 2'd1, 2'd2, 32'h12, 4'hF, 32'h0, 0, 0, 0);
      txn(3'd4, 2'd0, 2'd3, 32'h13, 4'hF, 32'h0, 0, 1, 0);

      // Reset while waiting: response dropped, write kept.
      send_a(3'd0, 2'd2, 2'd1, 32'h20, 4'hF, 32'hA5A5_5A5A);
      reset_i = 1'b1;
      #1;
      check("mid_rst_a_ready", 32'(tl.a_ready), 32'd0);
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      exp_q.delete();
      #1;
      check("post_rst_a_ready", 32'(tl.a_ready), 32'd1);
      seen = 1'b0;
      repeat (LAT + 3) begin
         @(posedge clk_i); #1;
         if (tl.d_valid) seen = 1'b1;
      end
      check("post_rst_no_d_valid", 32'(seen), 32'd0);
      txn(3'd4, 2'd2, 2'd1, 32'h20, 4'hF, 32'h0, 0, 0, 0);

      // Random legal traffic over a small window of words.
      for (int i = 0; i < 100; i++) begin
         int          w;
         int          kind;
         int          stall;
         bit          early;
         logic [1:0]  src;
         logic [1:0]  sz;
         logic [31:0] a;
         w     = 64 + int'($urandom_range(0, 15));
         kind  = int'($urandom_range(0, 2));
         src   = 2'($urandom_range(0, 3));
         stall = int'($urandom_range(0, 3));
         early = (stall == 0) && ($urandom_range(0, 1) == 1);
         if (!model_mem.exists(w)) kind = 0;
         case (kind)
            0: txn(3'd0, 2'd2, src, 32'(w * 4), 4'hF, $urandom, stall, early, 0);
            1: txn(3'd1, 2'd2, src, 32'(w * 4), 4'($urandom_range(1, 15)), $urandom, stall, early, 0);
            default: begin
               sz = 2'($urandom_range(0, 2));
               a  = 32'(w * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
               txn(3'd4, sz, src, a, 4'hF, 32'h0, stall, early, 0);
            end
         endcase
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
